data_memory_pipe: RTL and testbench
===================================

// Module: data_memory_pipe
// PURPOSE
//   Parametrised single-port data RAM with a valid/ready request channel and a
//   buffered read-response channel. Generalises the 8x256 data memory to
//   configurable width/depth, byte-lane write enables, registered reads with
//   back-pressure, and out-of-range detection. Sits between the datapath
//   load/store unit and on-chip storage.
// PARAMETERS
//   DATA_W   8             data width in bits; must be a multiple of 8
//   ADDR_W   8             address width in bits
//   DEPTH    (1<<ADDR_W)   number of words; DEPTH <= 2**ADDR_W
//   LANES    DATA_W/8      derived; byte lanes per word (not overridden)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   req_valid  in   1       request present
//   req_ready  out  1       block can accept a request this cycle
//   req_we     in   1       1 = write, 0 = read
//   req_addr   in   ADDR_W  word address
//   req_wdata  in   DATA_W  write data
//   req_be     in   LANES   byte-lane write enables (bit k -> bits 8k+7:8k)
//   rsp_valid  out  1       read response present
//   rsp_ready  in   1       consumer accepts response
//   rsp_rdata  out  DATA_W  read data
//   rsp_err    out  1       response is for an out-of-range address
// BEHAVIOUR
//   - Accept: request transfers on posedge clk when req_valid && req_ready;
//     applies to reads and writes alike (strict program order).
//   - Write: lanes with req_be[k]=1 updated at the accept edge; others kept.
//     No response generated. req_be=0 is a legal no-op write.
//   - Read: word sampled at accept edge, pushed into a 2-entry response FIFO.
//     Latency 1: rsp_valid high the cycle after accept if FIFO was empty.
//   - A read accepted the cycle after a write to the same address returns
//     the new data (write committed at earlier edge).
//   - Response FIFO: count 0..2; pop when rsp_valid && rsp_ready; push on
//     accepted read. Push+pop same cycle: count unchanged, order preserved.
//   - req_ready = (count != 2); registered-state only, no combinational path
//     from rsp_ready or req_valid. When count==2, writes also stall.
//   - rsp_rdata/rsp_err hold stable while rsp_valid && !rsp_ready.
//   - Out of range (req_addr >= DEPTH): write ignored, memory unchanged;
//     read pushes rdata=0, rsp_err=1. In-range reads push rsp_err=0.
//   - Reset (async assert, deassert sync to clk): count=0, rsp_valid=0,
//     rsp_rdata=0, rsp_err=0, req_ready=1 on first cycle after release.
//     Pending responses discarded; RAM contents NOT cleared by reset.
//   - RAM contents initialised to all zeros at time 0 (simulation/FPGA init).
//   - rsp_rdata drives 0 whenever rsp_valid=0.
// TESTING
//   1 Defaults; write 0xA5 @0x10 be=1, read @0x10, rsp_ready=1 -> rsp_valid
//     one cycle after read accept, rsp_rdata=0xA5, rsp_err=0.
//   2 DATA_W=32: write 0x11223344 be=1111 @3, then 0xAABBCCDD be=0101 @3,
//     read @3 -> 0x11BB33DD.
//   3 rsp_ready=0, issue 3 back-to-back reads @0,1,2 -> 2 accepted,
//     req_ready=0 on 3rd; release rsp_ready -> responses in order, 3rd
//     accepted the cycle after first pop; data stable while stalled.
//   4 DEPTH=200, ADDR_W=8: write 0x5A @250, read @250 -> rdata=0, rsp_err=1;
//     read @199 after write 0x7E -> 0x7E, rsp_err=0.
//   5 Fill FIFO (2 reads, rsp_ready=0), assert rst mid-cycle -> rsp_valid=0
//     immediately, req_ready=1 after release; prior writes still readable.
//   6 Write then read same address on consecutive cycles -> new data returned.

Source files
------------

// File: rtl/data_memory_pipe.sv
// data_memory_pipe
//   Single-port data RAM behind a valid/ready request channel. A read response
//   leaves through a 2-entry response FIFO, so the consumer can hold off
//   responses without losing any. Writes use per-byte lane enables. Addresses
//   at or above DEPTH are flagged as errors instead of touching storage.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle (registered state only)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte-lane write enables, bit k -> bits 8k+7:8k
//   rsp_valid  read response present
//   rsp_ready  consumer takes the response
//   rsp_rdata  read data, 0 when rsp_valid is low
//   rsp_err    response belongs to an out-of-range address
module data_memory_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = (1 << ADDR_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int LANES = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Storage is zeroed at time 0 and deliberately left alone by reset.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [DATA_W-1:0] fifo_data [2];
    logic              fifo_err  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              accept;
    logic              push;
    logic              pop;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    assign req_ready = (count != 2'd2);
    assign rsp_valid = (count != 2'd0);

    assign accept   = req_valid && req_ready;
    assign push     = accept && !req_we;
    assign pop      = rsp_valid && rsp_ready;
    assign in_range = ({1'b0, req_addr} < DEPTH_L);
    assign rd_word  = in_range ? mem[req_addr] : '0;

    always_ff @(posedge clk) begin
        if (accept && req_we && in_range) begin
            for (int k = 0; k < LANES; k++) begin
                if (req_be[k]) begin
                    mem[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // A push never happens when full (req_ready low), and a pop needs at
    // least one entry, so push+pop always targets distinct slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_err[0]  <= 1'b0;
            fifo_err[1]  <= 1'b0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rd_word;
                fifo_err[wr_ptr]  <= !in_range;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_err   = rsp_valid ? fifo_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe
//   Directed bench for data_memory_pipe. Instance u_dut_a uses default
//   parameters (8-bit x 256); u_dut_b is 32-bit wide with DEPTH=200 for the
//   byte-lane and out-of-range cases.
module tb_data_memory_pipe;

    logic clk = 1'b0;
    logic rst;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [7:0]  a_req_addr, a_req_wdata;
    logic [0:0]  a_req_be;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [7:0]  a_rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_memory_pipe u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    data_memory_pipe #(.DATA_W(32), .ADDR_W(8), .DEPTH(200)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic a_wait_ready();
        int n = 0;
        while (!a_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_req_ready) check("a_ready_timeout", 32'(a_req_ready), 32'd1);
    endtask

    task automatic b_wait_ready();
        int n = 0;
        while (!b_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!b_req_ready) check("b_ready_timeout", 32'(b_req_ready), 32'd1);
    endtask

    task automatic a_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = addr;
        a_req_wdata = data; a_req_be = 1'b1;
        a_wait_ready();
        @(posedge clk); #1;
        a_req_valid = 1'b0; a_req_we = 1'b0;
    endtask

    // Read with rsp_ready high and an empty FIFO: response must appear right
    // after the accept edge.
    task automatic a_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = addr;
        a_wait_ready();
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check({tag, "_valid"}, 32'(a_rsp_valid), 32'd1);
        check({tag, "_data"},  32'(a_rsp_rdata), 32'(exp));
        check({tag, "_err"},   32'(a_rsp_err),   32'd0);
        @(posedge clk); #1;
        check({tag, "_popped"}, 32'(a_rsp_valid), 32'd0);
    endtask

    task automatic b_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = addr;
        b_req_wdata = data; b_req_be = be;
        b_wait_ready();
        @(posedge clk); #1;
        b_req_valid = 1'b0; b_req_we = 1'b0;
    endtask

    task automatic b_read(input string tag, input logic [7:0] addr,
                          input logic [31:0] exp, input logic exp_err);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = addr;
        b_wait_ready();
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        check({tag, "_valid"}, 32'(b_rsp_valid), 32'd1);
        check({tag, "_data"},  b_rsp_rdata,      exp);
        check({tag, "_err"},   32'(b_rsp_err),   32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
        b_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 32'(a_req_ready), 32'd1);
        check("rst_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_rdata", 32'(a_rsp_rdata), 32'd0);
        check("rst_err",   32'(a_rsp_err),   32'd0);

        // Basic write/read on default geometry.
        a_write(8'h10, 8'hA5);
        a_read("t1", 8'h10, 8'hA5);

        // Read issued the cycle right after a write to the same address.
        a_write(8'h20, 8'h3C);
        a_read("t6", 8'h20, 8'h3C);
        a_read("init_zero", 8'h77, 8'h00);

        // Back-pressure: two reads fill the FIFO, third stalls.
        a_write(8'h00, 8'h11);
        a_write(8'h01, 8'h22);
        a_write(8'h02, 8'h33);
        a_rsp_ready = 1'b0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'h00;
        check("t3_ready0", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_addr = 8'h01;
        check("t3_first_valid", 32'(a_rsp_valid), 32'd1);
        check("t3_first_data",  32'(a_rsp_rdata), 32'h11);
        @(posedge clk); #1;
        a_req_addr = 8'h02;
        check("t3_full_ready", 32'(a_req_ready), 32'd0);
        @(posedge clk); #1;
        check("t3_stall_ready", 32'(a_req_ready), 32'd0);
        check("t3_stall_data",  32'(a_rsp_rdata), 32'h11);
        @(negedge clk); a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_pop1_data",  32'(a_rsp_rdata), 32'h22);
        check("t3_pop1_ready", 32'(a_req_ready), 32'd1);
        // Third read is accepted here while 0x22 pops: count stays at one.
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("t3_third_valid", 32'(a_rsp_valid), 32'd1);
        check("t3_third_data",  32'(a_rsp_rdata), 32'h33);
        @(posedge clk); #1;
        check("t3_drained_valid", 32'(a_rsp_valid), 32'd0);
        check("t3_drained_rdata", 32'(a_rsp_rdata), 32'd0);

        // Reset in the middle of a cycle with a full FIFO.
        a_write(8'h05, 8'h5C);
        a_rsp_ready = 1'b0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'h00;
        repeat (2) @(posedge clk);
        #1 a_req_valid = 1'b0;
        check("t5_full", 32'(a_req_ready), 32'd0);
        @(negedge clk); rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(a_rsp_valid), 32'd0);
        check("t5_rst_rdata", 32'(a_rsp_rdata), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("t5_rel_ready", 32'(a_req_ready), 32'd1);
        check("t5_rel_valid", 32'(a_rsp_valid), 32'd0);
        a_rsp_ready = 1'b1;
        a_read("t5_keep", 8'h05, 8'h5C);
        a_read("t5_keep2", 8'h10, 8'hA5);

        // Byte lanes on the 32-bit instance.
        b_write(8'd3, 32'h11223344, 4'b1111);
        b_write(8'd3, 32'hAABBCCDD, 4'b0101);
        b_read("t2", 8'd3, 32'h11BB33DD, 1'b0);
        b_write(8'd3, 32'hFFFFFFFF, 4'b0000);
        b_read("be0", 8'd3, 32'h11BB33DD, 1'b0);

        // Out-of-range handling with DEPTH=200.
        b_write(8'd250, 32'h0000005A, 4'b1111);
        b_read("t4_oor", 8'd250, 32'h0, 1'b1);
        b_write(8'd199, 32'h0000007E, 4'b1111);
        b_read("t4_last", 8'd199, 32'h7E, 1'b0);
        b_read("t4_200", 8'd200, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
